usb_tx_encoder: RTL and testbench
=================================

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, clock cycles per USB bit time (legal range 4..16).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port tx_start  input  1  one-cycle request to begin a packet; honoured only in IDLE.
REQ-005 SHALL have port tx_data  input  1  next raw (unstuffed) bit, LSB-first order supplied by upstream.
REQ-006 SHALL have port tx_data_valid  input  1  tx_data/tx_last hold a valid bit.
REQ-007 SHALL have port tx_last  input  1  qualifies tx_data as final raw bit of packet.
REQ-008 SHALL have port tx_data_ready  output  1  one-cycle pulse: current raw bit consumed.
REQ-009 SHALL have port d_plus  output  1  registered D+ line drive.
REQ-010 SHALL have port d_minus  output  1  registered D- line drive.
REQ-011 SHALL have port tx_busy  output  1  high from the cycle after accepted tx_start until return to IDLE.
REQ-012 SHALL have port stuff_inserted  output  1  one-cycle pulse when a stuff bit is launched.
REQ-013 SHALL have port tx_underrun  output  1  one-cycle pulse when a data bit is required but tx_data_valid is low.

Function
REQ-014 SHALL implement states IDLE, SEND, STUFF, EOP_SE0, EOP_J.
REQ-015 SHALL keep a bit timer 0..CLKS_PER_BIT-1; boundary cycle = timer at CLKS_PER_BIT-1; timer wraps to 0 after boundary.
REQ-016 SHALL, on tx_start in IDLE, load timer with CLKS_PER_BIT-1, enter SEND, and assert tx_busy next cycle; tx_start while busy SHALL be ignored.
REQ-017 SHALL, at each SEND boundary with tx_data_valid high, sample tx_data/tx_last, pulse tx_data_ready that cycle, and update lines the following cycle.
REQ-018 SHALL NRZI-encode: bit 0 toggles line state (J<->K), bit 1 holds; J = d_plus 1/d_minus 0, K = d_plus 0/d_minus 1.
REQ-019 SHALL keep a 3-bit ones counter: increment on launched 1, clear on launched 0 or stuff bit, clear on tx_start.
REQ-020 SHALL, when the ones counter reaches 6, enter STUFF; next boundary launches a 0 (toggle), pulses stuff_inserted, consumes no data (tx_data_ready low), then returns to SEND.
REQ-021 SHALL, after the tx_last bit is launched, go to EOP_SE0 at next boundary unless a stuff bit is pending, in which case the stuff bit SHALL be sent first.
REQ-022 SHALL in EOP_SE0 drive d_plus 0/d_minus 0 for exactly 2 bit times, then EOP_J drive J for 1 bit time, then IDLE with tx_busy low.
REQ-023 SHALL, at a SEND boundary with tx_data_valid low, pulse tx_underrun and go directly to EOP_SE0 (abort).
REQ-024 SHALL drive J in IDLE; all outputs registered, no combinational input-to-output paths except none.
REQ-025 SHALL never launch more than 6 consecutive held (1) bits between tx_start and EOP.

Reset
REQ-026 SHALL, on n_rst low (any state, including mid-packet), immediately force IDLE, d_plus 1, d_minus 0, tx_busy 0, tx_data_ready 0, stuff_inserted 0, tx_underrun 0, timer 0, ones counter 0.
REQ-027 SHALL leave reset in IDLE and ignore tx_start in the cycle n_rst deasserts only if asynchronously sampled low at that edge.

Verification (CLKS_PER_BIT = 8)
REQ-028 SHALL verify 8 raw 0s (last on 8th): lines K,J,K,J,K,J,K,J, 8 clocks each, 8 ready pulses 8 clocks apart, then SE0 16 clocks, J 8 clocks, tx_busy low.
REQ-029 SHALL verify 7 raw 1s then tx_last 0: line holds J 48 clocks, stuff bit K with stuff_inserted pulse and no ready in that slot, 7th 1 holds K, final 0 to J, then EOP.
REQ-030 SHALL verify tx_last on 6th consecutive 1: stuff bit (toggle) precedes SE0; total slots = 7 before EOP.
REQ-031 SHALL verify tx_data_valid dropped at 4th boundary: tx_underrun pulse that cycle, SE0 from next cycle for 16 clocks, J 8, IDLE.
REQ-032 SHALL verify n_rst pulsed low mid-STUFF: outputs at reset values asynchronously; subsequent tx_start sends cleanly with ones counter restarted.
REQ-033 SHALL verify tx_start reasserted during SEND and EOP_J: no effect on waveform, busy, or ready count.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// USB transmit encoder: NRZI line coding with bit stuffing and SE0/J end-of-packet.
// Decisions are taken at the bit-time boundary edge; all outputs, pulses included, are registered.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tx_start,
    input  logic tx_data,
    input  logic tx_data_valid,
    input  logic tx_last,
    output logic tx_data_ready,
    output logic d_plus,
    output logic d_minus,
    output logic tx_busy,
    output logic stuff_inserted,
    output logic tx_underrun
);
    localparam int              TW    = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   T_MAX = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, SEND, STUFF, EOP_SE0, EOP_J} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    ones_q, ones_d;
    logic          last_q, last_d;          // final raw bit already on the line
    logic          eop_half_q, eop_half_d;  // first SE0 bit time completed
    logic          dp_q, dp_d;
    logic          dm_q, dm_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          stuff_q, stuff_d;
    logic          under_q, under_d;
    logic          boundary;

    assign boundary = (timer_q == T_MAX);

    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        timer_d    = boundary ? '0 : timer_q + TW'(1);
        ones_d     = ones_q;
        last_d     = last_q;
        eop_half_d = eop_half_q;
        dp_d       = dp_q;
        dm_d       = dm_q;
        ready_d    = 1'b0;
        stuff_d    = 1'b0;
        under_d    = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (tx_start) begin
                    state_d    = SEND;
                    timer_d    = T_MAX;
                    ones_d     = '0;
                    last_d     = 1'b0;
                    eop_half_d = 1'b0;
                end
            end
            SEND: if (boundary) begin
                if (last_q) begin
                    state_d = EOP_SE0;
                    dp_d    = 1'b0;
                    dm_d    = 1'b0;
                end else if (tx_data_valid) begin
                    ready_d = 1'b1;
                    last_d  = tx_last;
                    if (tx_data) begin
                        ones_d = ones_q + 3'd1;
                        if (ones_q == 3'd5) state_d = STUFF;
                    end else begin
                        ones_d = '0;
                        dp_d   = ~dp_q;
                        dm_d   = ~dm_q;
                    end
                end else begin
                    // Upstream starved: abort straight into EOP.
                    under_d = 1'b1;
                    state_d = EOP_SE0;
                    dp_d    = 1'b0;
                    dm_d    = 1'b0;
                end
            end
            STUFF: if (boundary) begin
                stuff_d = 1'b1;
                ones_d  = '0;
                dp_d    = ~dp_q;
                dm_d    = ~dm_q;
                state_d = SEND;
            end
            EOP_SE0: if (boundary) begin
                if (eop_half_q) begin
                    state_d    = EOP_J;
                    eop_half_d = 1'b0;
                    dp_d       = 1'b1;
                    dm_d       = 1'b0;
                end else begin
                    eop_half_d = 1'b1;
                end
            end
            EOP_J: if (boundary) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            ones_q     <= '0;
            last_q     <= 1'b0;
            eop_half_q <= 1'b0;
            dp_q       <= 1'b1;
            dm_q       <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            stuff_q    <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ones_q     <= ones_d;
            last_q     <= last_d;
            eop_half_q <= eop_half_d;
            dp_q       <= dp_d;
            dm_q       <= dm_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            stuff_q    <= stuff_d;
            under_q    <= under_d;
        end
    end

    assign d_plus         = dp_q;
    assign d_minus        = dm_q;
    assign tx_busy        = busy_q;
    assign tx_data_ready  = ready_q;
    assign stuff_inserted = stuff_q;
    assign tx_underrun    = under_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: a packet-level model predicts timestamped line/pulse
// events, and an independent monitor compares every observed output event against them.
module tb_usb_tx_encoder;
    localparam int         CPB     = 8;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    typedef struct packed {
        longint     cyc;
        logic [1:0] sym;
        logic       rdy;
        logic       stf;
        logic       und;
        logic       busy;
    } ev_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic tx_start = 1'b0;
    logic tx_data = 1'b0;
    logic tx_data_valid = 1'b0;
    logic tx_last = 1'b0;
    logic tx_data_ready, d_plus, d_minus, tx_busy, stuff_inserted, tx_underrun;

    longint     cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    ev_t        exp_q[$];
    bit         pkt[$];
    bit         mon_en = 1'b0;
    logic [1:0] prev_sym = SYM_J;
    logic       prev_busy = 1'b0;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_last       (tx_last),
        .tx_data_ready (tx_data_ready),
        .d_plus        (d_plus),
        .d_minus       (d_minus),
        .tx_busy       (tx_busy),
        .stuff_inserted(stuff_inserted),
        .tx_underrun   (tx_underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(longint c, logic [1:0] s, logic r, logic st, logic u, logic b);
        ev_t e;
        e.cyc  = c;
        e.sym  = s;
        e.rdy  = r;
        e.stf  = st;
        e.und  = u;
        e.busy = b;
        exp_q.push_back(e);
    endfunction

    // Packet-level reference: walk the raw bits, apply NRZI and the six-ones stuffing rule,
    // and emit one event per bit slot plus the EOP edges. c0 is the cycle busy first shows high.
    task automatic model_packet(input longint c0, input int u);
        bit     j = 1'b1;
        int     ones = 0;
        bit     aborted = 1'b0;
        longint t = c0 + 1;
        push(c0, SYM_J, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < pkt.size() && !aborted; i++) begin
            if (i == u) begin
                aborted = 1'b1;
                push(t, SYM_SE0, 1'b0, 1'b0, 1'b1, 1'b1);
            end else begin
                if (pkt[i]) ones++;
                else begin
                    j    = !j;
                    ones = 0;
                end
                push(t, j ? SYM_J : SYM_K, 1'b1, 1'b0, 1'b0, 1'b1);
                t += CPB;
                if (ones == 6) begin
                    j    = !j;
                    ones = 0;
                    push(t, j ? SYM_J : SYM_K, 1'b0, 1'b1, 1'b0, 1'b1);
                    t += CPB;
                end
            end
        end
        if (!aborted) push(t, SYM_SE0, 1'b0, 1'b0, 1'b0, 1'b1);
        t += 2 * CPB;
        push(t, SYM_J, 1'b0, 1'b0, 1'b0, 1'b1);
        t += CPB;
        push(t, SYM_J, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        ev_t obs;
        ev_t e;
        obs.cyc  = cyc;
        obs.sym  = {d_plus, d_minus};
        obs.rdy  = tx_data_ready;
        obs.stf  = stuff_inserted;
        obs.und  = tx_underrun;
        obs.busy = tx_busy;
        if (mon_en && (obs.rdy || obs.stf || obs.und || obs.sym != prev_sym || obs.busy != prev_busy)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL event: got cyc=%0d sym=%b rdy=%b stf=%b und=%b busy=%b, expected no event",
                         obs.cyc, obs.sym, obs.rdy, obs.stf, obs.und, obs.busy);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL event: got cyc=%0d sym=%b rdy=%b stf=%b und=%b busy=%b, expected cyc=%0d sym=%b rdy=%b stf=%b und=%b busy=%b",
                             obs.cyc, obs.sym, obs.rdy, obs.stf, obs.und, obs.busy,
                             e.cyc, e.sym, e.rdy, e.stf, e.und, e.busy);
                end
            end
        end
        prev_sym  = obs.sym;
        prev_busy = obs.busy;
    end

    task automatic present(input int idx, input int u);
        if (idx == u || idx >= pkt.size()) begin
            tx_data_valid = 1'b0;
            tx_data       = 1'($urandom_range(1));
            tx_last       = 1'($urandom_range(1));
        end else begin
            tx_data_valid = 1'b1;
            tx_data       = pkt[idx];
            tx_last       = (idx == pkt.size() - 1);
        end
    endtask

    // Upstream driver: offers the raw bits, advances on each ready pulse, optionally
    // sprinkles tx_start while busy (must be ignored).
    task automatic run_packet(input int u, input bit noise);
        longint c0;
        int     idx = 0;
        int     budget = 0;
        @(negedge clk);
        c0 = cyc + 1;
        model_packet(c0, u);
        tx_start = 1'b1;
        present(0, u);
        @(negedge clk);
        tx_start = 1'b0;
        while (tx_busy && budget < 5000) begin
            if (tx_data_ready) begin
                idx++;
                present(idx, u);
            end
            tx_start = noise ? ($urandom_range(3) == 0) : 1'b0;
            @(negedge clk);
            budget++;
        end
        tx_start      = 1'b0;
        tx_data_valid = 1'b0;
        #1;
        check("packet_ends", tx_busy, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic fill_random(input int n, input int one_weight);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back($urandom_range(99) < one_weight);
    endtask

    initial begin
        int cnt;
        int budget;
        int n;
        int u;

        repeat (3) @(negedge clk);
        check("rst_d_plus", d_plus, 1'b1);
        check("rst_d_minus", d_minus, 1'b0);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_ready", tx_data_ready, 1'b0);
        check("rst_stuff", stuff_inserted, 1'b0);
        check("rst_underrun", tx_underrun, 1'b0);
        n_rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        pkt.delete();
        repeat (8) pkt.push_back(1'b0);
        run_packet(-1, 1'b0);

        pkt.delete();
        repeat (7) pkt.push_back(1'b1);
        pkt.push_back(1'b0);
        run_packet(-1, 1'b0);

        pkt.delete();
        repeat (6) pkt.push_back(1'b1);
        run_packet(-1, 1'b0);

        fill_random(8, 50);
        run_packet(3, 1'b0);

        fill_random(12, 70);
        run_packet(-1, 1'b1);

        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(1, 40);
            fill_random(n, 75);
            u = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
            run_packet(u, 1'($urandom_range(1)));
        end

        // Reset asserted while a stuff bit is pending, line sitting at K.
        mon_en = 1'b0;
        @(negedge clk);
        tx_start      = 1'b1;
        tx_data_valid = 1'b1;
        tx_data       = 1'b0;
        tx_last       = 1'b0;
        @(negedge clk);
        tx_start = 1'b0;
        cnt      = 0;
        budget   = 0;
        while (cnt < 7 && budget < 200) begin
            if (tx_data_ready) begin
                cnt++;
                tx_data = 1'b1;
            end
            @(negedge clk);
            budget++;
        end
        check("stuff_reached", cnt, 7);
        check("line_k_before_rst", {d_plus, d_minus}, SYM_K);
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_d_plus", d_plus, 1'b1);
        check("async_rst_d_minus", d_minus, 1'b0);
        check("async_rst_busy", tx_busy, 1'b0);
        check("async_rst_ready", tx_data_ready, 1'b0);
        check("async_rst_stuff", stuff_inserted, 1'b0);
        check("async_rst_underrun", tx_underrun, 1'b0);
        tx_data_valid = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        mon_en = 1'b1;

        pkt.delete();
        repeat (8) pkt.push_back(1'b1);
        pkt.push_back(1'b0);
        run_packet(-1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
